// File: rtl/bmc_sweep_encoder_if.sv
// Word/handshake bundle between a BMC encoder and whatever feeds or consumes it.
// The master side supplies the word and start request; the slave side returns status and the line.
interface bmc_sweep_encoder_if #(
  parameter int WORD_BITS = 17
);
  logic [WORD_BITS-1:0] word_in;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 envelop_out;
  logic                 data_out;

  modport master (
    output word_in, start,
    input  busy, done, envelop_out, data_out
  );

  modport slave (
    input  word_in, start,
    output busy, done, envelop_out, data_out
  );
endinterface

// File: rtl/bmc_sweep_encoder.sv
// Biphase-mark serializer: latches one word on start and sends it MSB-first,
// HALF_BIT_CYCLES clocks per half-bit, framed by envelop_out and followed by a one-bit tail.
module bmc_sweep_encoder #(
  parameter int HALF_BIT_CYCLES = 8,
  parameter int WORD_BITS       = 17
) (
  input  logic              clk_25MHz,
  input  logic              reset_n,
  bmc_sweep_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(2 * HALF_BIT_CYCLES);
  localparam int IDX_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * HALF_BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BITS,
    S_TAIL
  } state_t;

  state_t               r_state;
  logic [WORD_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_data;
  logic                 r_envelop;
  logic                 r_busy;
  logic                 r_done;

  // The bit on the line is always the MSB of the shift register.
  logic w_cur_bit;
  assign w_cur_bit = r_shift[WORD_BITS-1];

  // NOTE: state uses non-blocking assignments so every branch reads the pre-edge
  // values; blocking here would let a toggle computed early leak into later tests.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_data    <= 1'b0;
      r_envelop <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.word_in;
            r_cnt     <= '0;
            r_idx     <= IDX_MSB;
            r_data    <= ~r_data;
            r_envelop <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_BITS;
          end
        end

        S_BITS: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_MID) begin
            if (w_cur_bit) r_data <= ~r_data;
          end else if (r_cnt == CNT_LAST) begin
            r_data <= ~r_data;
            r_cnt  <= '0;
            if (r_idx != '0) begin
              r_idx   <= r_idx - 1'b1;
              r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
            end else begin
              r_state <= S_TAIL;
            end
          end
        end

        S_TAIL: begin
          r_cnt <= r_cnt + 1'b1;
          // The line parks at 0 so the next leading transition is always 0->1.
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_data    <= 1'b0;
            r_envelop <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out    = r_data;
  assign bus.envelop_out = r_envelop;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
